dmem_responder: RTL

Data-memory responder for the five-stage core: the memory-side end of the load/store interface the execute/memory stage drives with an address, a write flag, `funct3` and store data. Accepts one request at a time over a valid/ready handshake and performs RV32I byte/half/word access with little-endian lane placement. Returns load data sign- or zero-extended per `funct3`, after a programmable fixed latency, over a second valid/ready handshake. Lets the pipeline see realistic multi-cycle memory, so stall logic can be built and tested against it.

---
 rtl/dmem_responder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory end of the core's load/store interface.
// It accepts one request at a time and does RV32I byte/half/word access with
// little-endian lane placement. The response comes back after a fixed
// LATENCY over a valid/ready handshake.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When it is defined,
// misaligned half/word accesses are rejected. When it is not defined, they
// are force-aligned.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 32'd2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0]      w_offset;
    logic [31:0]      w_word_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_range_err;
    logic             w_align_err;
    logic             w_err;
    logic [1:0]       w_lane;
    logic             w_accept;
    logic             w_we;
    logic [31:0]      w_rd_word;

    // Flags a funct3 that is not a legal RV32I load/store encoding.
    function automatic logic f3_illegal(input logic wr, input logic [2:0] f3);
        logic bad;
        case (f3)
            3'b000, 3'b001, 3'b010: bad = 1'b0;
            3'b100, 3'b101:         bad = wr;
            default:                bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Returns 1 for a half access on an odd byte, or a word access that is not on a word boundary.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lane[0];
            2'b10:   mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Picks the byte or half at the lane and sign- or zero-extends it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Merges right-aligned store data into the addressed lanes. The other lanes keep their old value.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] mask;
        logic [31:0] data;
        case (f3)
            3'b000: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {4{wdata[7:0]}};
            end
            3'b001: begin
                mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                data = {2{wdata[15:0]}};
            end
            3'b010: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
            default: begin
                mask = 32'h0000_0000;
                data = 32'h0000_0000;
            end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    assign w_offset   = req_addr - BASE_ADDR;
    assign w_word_off = w_offset >> 2;
    assign w_idx      = w_word_off[IDX_W-1:0];
    assign w_rd_word  = r_mem[w_idx];

    // Decodes the request: range check, effective lane and misalignment error.
    always_comb begin
        w_range_err = (req_addr < BASE_ADDR) || (w_word_off >= DEPTH_L);
`ifdef DMEM_MISALIGN_TRAP_EN
        w_align_err = misaligned(req_funct3, req_addr[1:0]);
        w_lane      = req_addr[1:0];
`else
        w_align_err = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_lane = {req_addr[1], 1'b0};
            2'b10:   w_lane = 2'b00;
            default: w_lane = req_addr[1:0];
        endcase
`endif
        w_err    = w_range_err | w_align_err | f3_illegal(req_write, req_funct3);
        w_accept = (r_state == ST_IDLE) && req_valid && !reset;
        w_we     = w_accept && req_write && !w_err;
    end

    // Storage write on the accept edge. Reset does not clear the contents.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_idx] <= store_merge(w_rd_word, req_wdata, req_funct3, w_lane);
        end
    end

    // Handshake FSM: it latches the response at accept, waits out the latency,
    // then holds the response until the consumer takes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err || req_write) ? 32'd0
                                       : load_extend(w_rd_word, req_funct3, w_lane);
                        if (LATENCY == 32'd1) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 4'd0;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
